// File: rtl/datapath_mc_pkg.sv
// datapath_mc_pkg
// Shared constants for the multi-cycle datapath: the 7-bit opcode values
// driven by decode/control, the FSM state type and a small decode helper.
// Optional feature macro: DATAPATH_REM_EN (REM handled by the divider).
package datapath_mc_pkg;

    localparam logic [6:0] OP_ADD  = 7'h01;
    localparam logic [6:0] OP_SUB  = 7'h02;
    localparam logic [6:0] OP_AND  = 7'h03;
    localparam logic [6:0] OP_OR   = 7'h04;
    localparam logic [6:0] OP_ADDI = 7'h05;
    localparam logic [6:0] OP_DIV  = 7'h06;
    localparam logic [6:0] OP_REM  = 7'h07;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    // True for every opcode that goes through the serial divider in this build.
    function automatic logic is_divider_op(input logic [6:0] op);
`ifdef DATAPATH_REM_EN
        return (op == OP_DIV) || (op == OP_REM);
`else
        return (op == OP_DIV);
`endif
    endfunction

endpackage

// File: rtl/datapath_mc_if.sv
// datapath_mc_if
// Request/response bundle between decode/control (master) and the datapath
// (slave).
//   Request : in_valid, in_ready, operation, rs1, rs2, rw, imm, write
//   Response: out_valid, result, zero_flag, illegal
// Parameters: XLEN data width, AW register index width.
interface datapath_mc_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      operation;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rw;
    logic [XLEN-1:0] imm;
    logic            write;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            zero_flag;
    logic            illegal;

    modport master (
        output in_valid, operation, rs1, rs2, rw, imm, write,
        input  in_ready, out_valid, result, zero_flag, illegal
    );

    modport slave (
        input  in_valid, operation, rs1, rs2, rw, imm, write,
        output in_ready, out_valid, result, zero_flag, illegal
    );
endinterface

// File: rtl/datapath_mc_serial_divider.sv
// serial_divider
// Unsigned restoring shift-subtract divider, one quotient bit per cycle.
// The first step is taken on the start edge straight from the input operands,
// so the final bit lands XLEN-1 edges later and done pulses in the cycle after.
// Ports:
//   clk, reset (async, active low)
//   start            load operands and take the first step
//   dividend/divisor operands, sampled on start
//   busy             iterations still in flight
//   done             one-cycle pulse, quotient/remainder valid and held
//   quotient         result of dividend / divisor
//   remainder        dividend % divisor (only built with DATAPATH_REM_EN)
// Divide by zero needs no special case: every trial subtract of 0 succeeds,
// giving an all-ones quotient and a remainder equal to the dividend.
module serial_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient
`ifdef DATAPATH_REM_EN
    ,
    output logic [XLEN-1:0] remainder
`endif
);
    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] dvsr_q;
    logic [CW-1:0]   count;

    // One restoring step on {partial remainder, remaining dividend bits}.
    // The partial remainder stays below the divisor, so the XLEN+1 bit trial
    // difference is negative exactly when its top bit is set.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r,
                                                   input logic [XLEN-1:0] q,
                                                   input logic [XLEN-1:0] d);
        logic [XLEN:0] trial;
        trial = {r, q[XLEN-1]} - {1'b0, d};
        if (trial[XLEN])
            return {r[XLEN-2:0], q[XLEN-1], q[XLEN-2:0], 1'b0};
        else
            return {trial[XLEN-1:0], q[XLEN-2:0], 1'b1};
    endfunction

    // Iteration register: load-and-step on start, then step until count runs out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {rem_q, quot_q} <= div_step('0, dividend, divisor);
                dvsr_q          <= divisor;
                count           <= CW'(XLEN - 1);
                busy            <= 1'b1;
            end else if (busy) begin
                {rem_q, quot_q} <= div_step(rem_q, quot_q, dvsr_q);
                count           <= count - CW'(1);
                if (count == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quot_q;
`ifdef DATAPATH_REM_EN
    assign remainder = rem_q;
`endif

endmodule

// File: rtl/datapath_mc.sv
// datapath_mc
// Multi-cycle register file + ALU datapath. One operation per valid/ready
// handshake; ADD/SUB/AND/OR/ADDI finish in one cycle, DIV (and REM when
// enabled) run on the serial divider and report XLEN+2 cycles after accept.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    datapath_mc_if slave: request fields in, result/zero_flag/
//          illegal with a one-cycle out_valid pulse out
// Parameters: XLEN data width (>= 8), NREGS register count (power of 2).
// Optional feature macro: DATAPATH_REM_EN enables REM; otherwise REM is
// reported as an illegal opcode.
module datapath_mc #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          reset,
    datapath_mc_if.slave  bus
);
    import datapath_mc_pkg::*;

    localparam int AW = $clog2(NREGS);

    state_t          state;
    state_t          next_state;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [XLEN-1:0] alu_value;
    logic            alu_legal;
    logic            is_div_op;
    logic            accept;
    logic            div_start;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_value;
    logic [AW-1:0]   pend_rw;
    logic            pend_write;
`ifdef DATAPATH_REM_EN
    logic [XLEN-1:0] div_rem;
    logic            pend_rem;
`endif

    // The divider's own busy flag also gates acceptance so its operand
    // registers are never reloaded mid-iteration.
    assign bus.in_ready = (state == IDLE) && !div_busy;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_div_op    = is_divider_op(bus.operation);
    assign div_start    = accept && is_div_op;

    assign rs1_value = (bus.rs1 == '0) ? '0 : regs[bus.rs1];
    assign rs2_value = (bus.rs2 == '0) ? '0 : regs[bus.rs2];

    // Single-cycle ALU; anything it does not know is flagged illegal and
    // yields zero, divider opcodes are filtered out before this is used.
    always_comb begin
        alu_value = '0;
        alu_legal = 1'b1;
        case (bus.operation)
            OP_ADD:  alu_value = rs1_value + rs2_value;
            OP_SUB:  alu_value = rs1_value - rs2_value;
            OP_AND:  alu_value = rs1_value & rs2_value;
            OP_OR:   alu_value = rs1_value | rs2_value;
            OP_ADDI: alu_value = rs1_value + bus.imm;
            default: alu_legal = 1'b0;
        endcase
    end

    serial_divider #(.XLEN(XLEN)) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (rs1_value),
        .divisor   (rs2_value),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot)
`ifdef DATAPATH_REM_EN
        ,
        .remainder (div_rem)
`endif
    );

`ifdef DATAPATH_REM_EN
    assign div_value = pend_rem ? div_rem : div_quot;
`else
    assign div_value = div_quot;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: divider ops park in DIV_RUN until the divider pulses
    // done, then spend one cycle in DIV_DONE to register and write back.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (div_start) next_state = DIV_RUN;
            DIV_RUN:  if (div_done) next_state = DIV_DONE;
            DIV_DONE: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Register file, response registers and the pending divider writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero_flag <= 1'b0;
            bus.illegal   <= 1'b0;
            pend_rw       <= '0;
            pend_write    <= 1'b0;
`ifdef DATAPATH_REM_EN
            pend_rem      <= 1'b0;
`endif
        end else begin
            bus.out_valid <= 1'b0;
            bus.illegal   <= 1'b0;
            if (accept && !is_div_op) begin
                bus.out_valid <= 1'b1;
                bus.illegal   <= !alu_legal;
                bus.result    <= alu_value;
                bus.zero_flag <= (alu_value == '0);
                if (alu_legal && bus.write && (bus.rw != '0))
                    regs[bus.rw] <= alu_value;
            end
            if (div_start) begin
                pend_rw    <= bus.rw;
                pend_write <= bus.write;
`ifdef DATAPATH_REM_EN
                pend_rem   <= (bus.operation == OP_REM);
`endif
            end
            if (state == DIV_DONE) begin
                bus.out_valid <= 1'b1;
                bus.result    <= div_value;
                bus.zero_flag <= (div_value == '0);
                if (pend_write && (pend_rw != '0))
                    regs[pend_rw] <= div_value;
            end
        end
    end

endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc
// Self-checking bench for datapath_mc: directed cases for the main
// behaviours, a mid-divide reset, then randomized operations compared
// against a register-array reference model. Honours DATAPATH_REM_EN.
module tb_datapath_mc;
    import datapath_mc_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    logic clk;
    logic reset;
    int   checks_done;
    int   fail_count;
    logic [XLEN-1:0] model_regs [NREGS];

    datapath_mc_if #(.XLEN(XLEN), .AW(AW)) bus ();

    datapath_mc #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global guard so a stuck handshake can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks_done++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference behaviour straight from the operation definitions.
    function automatic void modelOp(input logic [6:0] op, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b, input logic [XLEN-1:0] immv,
                                    output logic [XLEN-1:0] res, output logic ill,
                                    output int lat);
        ill = 1'b0;
        lat = 1;
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADDI: res = a + immv;
            OP_DIV: begin
                lat = XLEN + 2;
                res = (b == 0) ? {XLEN{1'b1}} : a / b;
            end
`ifdef DATAPATH_REM_EN
            OP_REM: begin
                lat = XLEN + 2;
                res = (b == 0) ? a : a % b;
            end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic scrambleInputs();
        bus.operation = 7'($urandom);
        bus.rs1       = AW'($urandom);
        bus.rs2       = AW'($urandom);
        bus.rw        = AW'($urandom);
        bus.imm       = XLEN'($urandom);
        bus.write     = 1'($urandom);
    endtask

    // Issues one operation at a negedge, then follows it to its out_valid
    // pulse and checks response, latency and ready; returns at that negedge.
    task automatic applyStimulus(input logic [6:0] op, input int r1, input int r2,
                                 input int rd, input logic [XLEN-1:0] immv,
                                 input logic wr);
        logic [XLEN-1:0] exp_res;
        logic            exp_ill;
        int              exp_lat;
        int              lat;
        modelOp(op, model_regs[r1], model_regs[r2], immv, exp_res, exp_ill, exp_lat);
        checkOutput("in_ready before accept", 64'(bus.in_ready), 64'(1));
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.rs1       = AW'(r1);
        bus.rs2       = AW'(r2);
        bus.rw        = AW'(rd);
        bus.imm       = immv;
        bus.write     = wr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scrambleInputs();
        lat = 1;
        @(negedge clk);
        if (exp_lat > 1)
            checkOutput("in_ready while dividing", 64'(bus.in_ready), 64'(0));
        while (!bus.out_valid && lat < exp_lat + 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(exp_lat));
        checkOutput("result", 64'(bus.result), 64'(exp_res));
        checkOutput("zero_flag", 64'(bus.zero_flag), 64'(exp_res == '0));
        checkOutput("illegal", 64'(bus.illegal), 64'(exp_ill));
        checkOutput("in_ready with out_valid", 64'(bus.in_ready), 64'(1));
        if (!exp_ill && wr && rd != 0)
            model_regs[rd] = exp_res;
    endtask

    task automatic idlePulseCheck();
        @(negedge clk);
        checkOutput("out_valid is a pulse", 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        logic [6:0] op;
        int         sel;
        checks_done = 0;
        fail_count  = 0;
        for (int i = 0; i < NREGS; i++)
            model_regs[i] = '0;
        bus.in_valid = 1'b0;
        scrambleInputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("reset result", 64'(bus.result), 64'(0));
        checkOutput("reset zero_flag", 64'(bus.zero_flag), 64'(0));
        checkOutput("reset illegal", 64'(bus.illegal), 64'(0));
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'(1));
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] directed single-cycle operations");
        applyStimulus(OP_ADDI, 0, 0, 5, XLEN'(7), 1'b1);
        checkOutput("addi x5 literal", 64'(bus.result), 64'(7));
        applyStimulus(OP_ADD, 5, 5, 11, XLEN'(0), 1'b1);
        checkOutput("add x11 literal", 64'(bus.result), 64'(14));
        applyStimulus(OP_OR, 0, 11, 0, XLEN'(0), 1'b0);
        checkOutput("read x11 literal", 64'(bus.result), 64'(14));
        applyStimulus(OP_SUB, 5, 5, 9, XLEN'(0), 1'b1);
        checkOutput("sub zero flag literal", 64'(bus.zero_flag), 64'(1));
        applyStimulus(OP_SUB, 0, 5, 12, XLEN'(0), 1'b1);
        checkOutput("sub wrap literal", 64'(bus.result), 64'(32'hFFFF_FFF9));
        applyStimulus(OP_AND, 12, 11, 13, XLEN'(0), 1'b1);
        applyStimulus(OP_ADDI, 0, 0, 6, XLEN'(100), 1'b1);
        applyStimulus(OP_ADDI, 0, 0, 7, XLEN'(7), 1'b1);

        $display("[TB] directed divider operations");
        applyStimulus(OP_DIV, 6, 7, 30, XLEN'(0), 1'b1);
        checkOutput("div literal", 64'(bus.result), 64'(14));
        idlePulseCheck();
        applyStimulus(OP_REM, 6, 7, 31, XLEN'(0), 1'b1);
        applyStimulus(OP_OR, 0, 31, 0, XLEN'(0), 1'b0);
        applyStimulus(OP_DIV, 6, 0, 14, XLEN'(0), 1'b1);
        checkOutput("div by zero literal", 64'(bus.result), 64'(32'hFFFF_FFFF));
        applyStimulus(OP_REM, 12, 0, 15, XLEN'(0), 1'b1);
        applyStimulus(OP_ADDI, 0, 0, 0, XLEN'(55), 1'b1);
        applyStimulus(OP_OR, 0, 0, 1, XLEN'(0), 1'b0);
        checkOutput("x0 stays zero", 64'(bus.result), 64'(0));
        applyStimulus(7'h7F, 5, 5, 16, XLEN'(0), 1'b1);
        applyStimulus(OP_OR, 16, 0, 0, XLEN'(0), 1'b0);

        $display("[TB] reset during divide");
        applyStimulus(OP_ADDI, 0, 0, 8, XLEN'(9), 1'b1);
        bus.in_valid  = 1'b1;
        bus.operation = OP_DIV;
        bus.rs1       = AW'(6);
        bus.rs2       = AW'(7);
        bus.rw        = AW'(20);
        bus.write     = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("abort result", 64'(bus.result), 64'(0));
        checkOutput("abort zero_flag", 64'(bus.zero_flag), 64'(0));
        checkOutput("abort in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NREGS; i++)
            model_regs[i] = '0;
        @(negedge clk);
        applyStimulus(OP_OR, 5, 11, 0, XLEN'(0), 1'b0);
        applyStimulus(OP_ADD, 6, 8, 0, XLEN'(0), 1'b0);
        applyStimulus(OP_OR, 20, 30, 0, XLEN'(0), 1'b0);

        $display("[TB] randomized operations");
        for (int i = 1; i < NREGS; i++)
            applyStimulus(OP_ADDI, 0, 0, i,
                          (i % 3 == 0) ? XLEN'($urandom_range(0, 300)) : XLEN'($urandom), 1'b1);
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       op = OP_ADD;
                1:       op = OP_SUB;
                2:       op = OP_AND;
                3:       op = OP_OR;
                4, 5:    op = OP_ADDI;
                6:       op = OP_DIV;
                7:       op = OP_REM;
                8:       op = 7'h40 | 7'($urandom_range(0, 63));
                default: op = OP_SUB;
            endcase
            applyStimulus(op, $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                          $urandom_range(0, NREGS - 1), XLEN'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < NREGS; i++)
            applyStimulus(OP_OR, i, 0, 0, XLEN'(0), 1'b0);
        idlePulseCheck();

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
        $finish;
    end

endmodule
